// File: rtl/cxu_l2_req_queue.sv
// rtl/cxu_l2_req_queue.sv - request FIFO and in-flight limiter in front of a CXU-L2 target
module cxu_l2_req_queue #(
    parameter int CXU_N_CXUS    = 2,
    parameter int CXU_N_STATES  = 1,
    parameter int CXU_FUNC_ID_W = 10,
    parameter int CXU_INSN_W    = 0,
    parameter int CXU_DATA_W    = 32,
    parameter int REQ_DEPTH     = 4,
    parameter int MAX_INFLIGHT  = 8,
    localparam int CXU_CXU_ID_W   = (CXU_N_CXUS > 1) ? $clog2(CXU_N_CXUS) : 1,
    localparam int CXU_STATE_ID_W = (CXU_N_STATES > 1) ? $clog2(CXU_N_STATES) : 1,
    localparam int INSN_W         = (CXU_INSN_W > 0) ? CXU_INSN_W : 1,
    localparam int Q_CNT_W        = $clog2(REQ_DEPTH) + 1,
    localparam int INF_W          = $clog2(MAX_INFLIGHT) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clk_en,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [CXU_CXU_ID_W-1:0]   req_cxu,
    input  logic [CXU_STATE_ID_W-1:0] req_state,
    input  logic [CXU_FUNC_ID_W-1:0]  req_func,
    input  logic [INSN_W-1:0]         req_insn,
    input  logic [CXU_DATA_W-1:0]     req_data0,
    input  logic [CXU_DATA_W-1:0]     req_data1,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [2:0]                resp_status,
    output logic [CXU_DATA_W-1:0]     resp_data,
    output logic                      t_req_valid,
    input  logic                      t_req_ready,
    output logic [CXU_CXU_ID_W-1:0]   t_req_cxu,
    output logic [CXU_STATE_ID_W-1:0] t_req_state,
    output logic [CXU_FUNC_ID_W-1:0]  t_req_func,
    output logic [INSN_W-1:0]         t_req_insn,
    output logic [CXU_DATA_W-1:0]     t_req_data0,
    output logic [CXU_DATA_W-1:0]     t_req_data1,
    input  logic                      t_resp_valid,
    output logic                      t_resp_ready,
    input  logic [2:0]                t_resp_status,
    input  logic [CXU_DATA_W-1:0]     t_resp_data,
    output logic [Q_CNT_W-1:0]        q_count,
    output logic [INF_W-1:0]          inflight,
    output logic                      err
);

    localparam int ENT_W = CXU_CXU_ID_W + CXU_STATE_ID_W + CXU_FUNC_ID_W + INSN_W + 2 * CXU_DATA_W;
    localparam int PTR_W = $clog2(REQ_DEPTH);
    localparam logic [Q_CNT_W-1:0] DEPTH_C = Q_CNT_W'(REQ_DEPTH);
    localparam logic [INF_W-1:0]   MAX_C   = INF_W'(MAX_INFLIGHT);

    logic [ENT_W-1:0]   mem_q [REQ_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [Q_CNT_W-1:0] count_q, count_d;
    logic [INF_W-1:0]   inflight_q, inflight_d;
    logic               err_q, err_d;
    logic               rdy_en_q, rdy_en_d;
    logic               req_fire, t_req_fire, resp_fire;
    logic [ENT_W-1:0]   req_ent;

    assign req_ent = {req_cxu, req_state, req_func, req_insn, req_data0, req_data1};

    // Ready depends only on flops so upstream never sees a path from t_req_ready.
    assign req_ready   = rdy_en_q && (count_q < DEPTH_C);
    assign t_req_valid = clk_en && (count_q != '0) && (inflight_q < MAX_C);
    assign {t_req_cxu, t_req_state, t_req_func, t_req_insn, t_req_data0, t_req_data1} = mem_q[rd_ptr_q];

    assign resp_valid   = t_resp_valid;
    assign resp_status  = t_resp_status;
    assign resp_data    = t_resp_data;
    assign t_resp_ready = resp_ready;

    assign q_count  = count_q;
    assign inflight = inflight_q;
    assign err      = err_q;

    always_comb begin
        req_fire   = req_valid && req_ready && clk_en;
        t_req_fire = t_req_valid && t_req_ready;
        resp_fire  = t_resp_valid && resp_ready && clk_en;

        wr_ptr_d   = wr_ptr_q + PTR_W'(req_fire);
        rd_ptr_d   = rd_ptr_q + PTR_W'(t_req_fire);
        rdy_en_d   = 1'b1;
        err_d      = err_q;

        count_d = count_q;
        case ({req_fire, t_req_fire})
            2'b10:   count_d = count_q + Q_CNT_W'(1);
            2'b01:   count_d = count_q - Q_CNT_W'(1);
            default: count_d = count_q;
        endcase

        inflight_d = inflight_q;
        if (resp_fire && (inflight_q == '0)) begin
            // Stray response: flag it and never let the counter wrap below zero.
            err_d      = 1'b1;
            inflight_d = t_req_fire ? INF_W'(1) : '0;
        end else begin
            case ({t_req_fire, resp_fire})
                2'b10:   inflight_d = inflight_q + INF_W'(1);
                2'b01:   inflight_d = inflight_q - INF_W'(1);
                default: inflight_d = inflight_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
            rdy_en_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
            rdy_en_q   <= rdy_en_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && req_fire) begin
            mem_q[wr_ptr_q] <= req_ent;
        end
    end

endmodule

// File: tb/tb_cxu_l2_req_queue.sv
// tb/tb_cxu_l2_req_queue.sv - scoreboard bench for cxu_l2_req_queue
module tb_cxu_l2_req_queue;

    typedef struct packed {
        logic        cxu;
        logic        state;
        logic [9:0]  func;
        logic        insn;
        logic [31:0] d0;
        logic [31:0] d1;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst, clk_en;
    logic        req_valid, req_ready;
    logic        req_cxu, req_state, req_insn;
    logic [9:0]  req_func;
    logic [31:0] req_data0, req_data1;
    logic        resp_valid, resp_ready;
    logic [2:0]  resp_status;
    logic [31:0] resp_data;
    logic        t_req_valid, t_req_ready;
    logic        t_req_cxu, t_req_state, t_req_insn;
    logic [9:0]  t_req_func;
    logic [31:0] t_req_data0, t_req_data1;
    logic        t_resp_valid, t_resp_ready;
    logic [2:0]  t_resp_status;
    logic [31:0] t_resp_data;
    logic [2:0]  q_count;
    logic [1:0]  inflight;
    logic        err;

    int n_vec = 0;
    int n_err = 0;
    int n_push = 0;
    int n_issued = 0;
    ent_t sb[$];

    always #5 clk = ~clk;

    cxu_l2_req_queue #(.MAX_INFLIGHT(2)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cxu(req_cxu), .req_state(req_state), .req_func(req_func), .req_insn(req_insn),
        .req_data0(req_data0), .req_data1(req_data1),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_status(resp_status), .resp_data(resp_data),
        .t_req_valid(t_req_valid), .t_req_ready(t_req_ready),
        .t_req_cxu(t_req_cxu), .t_req_state(t_req_state), .t_req_func(t_req_func),
        .t_req_insn(t_req_insn), .t_req_data0(t_req_data0), .t_req_data1(t_req_data1),
        .t_resp_valid(t_resp_valid), .t_resp_ready(t_resp_ready),
        .t_resp_status(t_resp_status), .t_resp_data(t_resp_data),
        .q_count(q_count), .inflight(inflight), .err(err)
    );

    // Advance one cycle; handshakes that will fire on the coming edge are scored at the negedge.
    task automatic step();
        ent_t g, e;
        @(negedge clk);
        if (!rst) begin
            if (t_req_valid && t_req_ready) begin
                g = {t_req_cxu, t_req_state, t_req_func, t_req_insn, t_req_data0, t_req_data1};
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL issue_order: got %h required <no entry>", g);
                end else begin
                    e = sb.pop_front();
                    if (g !== e) begin n_err++; $display("FAIL issue_order: got %h required %h", g, e); end
                end
                n_issued++;
            end
            if (inflight > 2'd2) begin n_err++; $display("FAIL inflight_cap: got %0d required <=2", inflight); end
            if (req_valid && req_ready && clk_en) begin
                sb.push_back({req_cxu, req_state, req_func, req_insn, req_data0, req_data1});
                n_push++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [31:0] d0, input logic [31:0] d1, input logic [9:0] f);
        req_data0 = d0;
        req_data1 = d1;
        req_func  = f;
        req_cxu   = 1'($urandom);
        req_state = 1'($urandom);
        req_insn  = 1'($urandom);
    endtask

    task automatic drain();
        int k = 0;
        t_req_ready = 1'b1;
        while (!(q_count == 0 && inflight == 0) && k < 60) begin
            t_resp_valid = (inflight != 0);
            step();
            k++;
        end
        t_resp_valid = 1'b0;
        n_vec++;
        if (q_count !== 3'd0 || inflight !== 2'd0) begin
            n_err++; $display("FAIL drain_timeout: got q=%0d inf=%0d required 0/0", q_count, inflight);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        t_resp_valid = 1'b1; t_resp_data = 32'hABCD_0123; t_resp_status = 3'd5;
        #1;
        n_vec++; if (resp_valid !== 1'b1 || resp_data !== 32'hABCD_0123 || resp_status !== 3'd5) begin
            n_err++; $display("FAIL reset_passthru: got %b %h %0d required 1 abcd0123 5", resp_valid, resp_data, resp_status); end
        step();
        t_resp_valid = 1'b0;
        n_vec++; if (q_count !== 3'd0) begin n_err++; $display("FAIL reset_qcount: got %0d required 0", q_count); end
        n_vec++; if (inflight !== 2'd0) begin n_err++; $display("FAIL reset_inflight: got %0d required 0", inflight); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b required 0", err); end
        n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL reset_req_ready: got %b required 0", req_ready); end
        n_vec++; if (t_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_t_req_valid: got %b required 0", t_req_valid); end
        rst = 1'b0;
        step();
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready: got %b required 1", req_ready); end
    endtask

    task automatic test_single();
        t_req_ready = 1'b0;
        set_req(32'd3, 32'd5, 10'd0);
        req_valid = 1'b1;
        #1;
        n_vec++; if (t_req_valid !== 1'b0) begin n_err++; $display("FAIL no_bypass: got %b required 0", t_req_valid); end
        step();
        req_valid = 1'b0;
        #1;
        n_vec++; if (t_req_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b required 1", t_req_valid); end
        n_vec++; if (t_req_data0 !== 32'd3 || t_req_data1 !== 32'd5 || t_req_func !== 10'd0) begin
            n_err++; $display("FAIL single_fields: got %0d %0d %0d required 3 5 0", t_req_data0, t_req_data1, t_req_func); end
        t_req_ready = 1'b1;
        step();
        n_vec++; if (inflight !== 2'd1) begin n_err++; $display("FAIL single_inflight_up: got %0d required 1", inflight); end
        t_resp_valid = 1'b1;
        step();
        t_resp_valid = 1'b0;
        #1;
        n_vec++; if (inflight !== 2'd0 || err !== 1'b0) begin
            n_err++; $display("FAIL single_inflight_down: got inf=%0d err=%b required 0 0", inflight, err); end
    endtask

    task automatic test_fill();
        int base = n_push;
        int ib = n_issued;
        int k = 0;
        t_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_req(32'(i), $urandom, 10'($urandom));
            req_valid = 1'b1;
            step();
        end
        set_req(32'd4, $urandom, 10'($urandom));
        #1;
        n_vec++; if (q_count !== 3'd4) begin n_err++; $display("FAIL fill_qcount: got %0d required 4", q_count); end
        n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL fill_req_ready: got %b required 0", req_ready); end
        step();
        n_vec++; if (q_count !== 3'd4 || n_push != base + 4) begin
            n_err++; $display("FAIL fill_fifth_held: got q=%0d pushes=%0d required 4 %0d", q_count, n_push - base, 4); end
        t_req_ready = 1'b1;
        while (!(n_issued == ib + 5 && inflight == 0) && k < 60) begin
            if (n_push >= base + 5) req_valid = 1'b0;
            t_resp_valid = (inflight != 0);
            step();
            k++;
        end
        req_valid = 1'b0;
        t_resp_valid = 1'b0;
        n_vec++; if (n_issued - ib != 5 || q_count !== 3'd0) begin
            n_err++; $display("FAIL fill_drain: got issued=%0d q=%0d required 5 0", n_issued - ib, q_count); end
    endtask

    task automatic test_inflight_cap();
        int ib = n_issued;
        t_req_ready = 1'b1;
        t_resp_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_req(32'(10 + i), $urandom, 10'($urandom));
            req_valid = 1'b1;
            step();
        end
        req_valid = 1'b0;
        step();
        step();
        n_vec++; if (n_issued - ib != 2 || t_req_valid !== 1'b0) begin
            n_err++; $display("FAIL cap_stall: got issued=%0d valid=%b required 2 0", n_issued - ib, t_req_valid); end
        n_vec++; if (q_count !== 3'd2 || inflight !== 2'd2) begin
            n_err++; $display("FAIL cap_counts: got q=%0d inf=%0d required 2 2", q_count, inflight); end
        t_resp_valid = 1'b1;
        step();
        t_resp_valid = 1'b0;
        #1;
        n_vec++; if (inflight !== 2'd1 || t_req_valid !== 1'b1) begin
            n_err++; $display("FAIL cap_release: got inf=%0d valid=%b required 1 1", inflight, t_req_valid); end
        step();
        n_vec++; if (inflight !== 2'd2 || q_count !== 3'd1 || n_issued - ib != 3) begin
            n_err++; $display("FAIL cap_reissue: got inf=%0d q=%0d issued=%0d required 2 1 3", inflight, q_count, n_issued - ib); end
    endtask

    task automatic test_back_to_back();
        t_resp_valid = 1'b1;
        step();
        n_vec++; if (inflight !== 2'd1 || t_req_valid !== 1'b1) begin
            n_err++; $display("FAIL b2b_setup: got inf=%0d valid=%b required 1 1", inflight, t_req_valid); end
        step();
        t_resp_valid = 1'b0;
        #1;
        n_vec++; if (inflight !== 2'd1 || q_count !== 3'd0) begin
            n_err++; $display("FAIL b2b_inflight_same: got inf=%0d q=%0d required 1 0", inflight, q_count); end
        t_req_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_req(32'(20 + i), $urandom, 10'($urandom));
            req_valid = 1'b1;
            step();
        end
        set_req(32'd22, $urandom, 10'($urandom));
        t_req_ready = 1'b1;
        step();
        req_valid = 1'b0;
        #1;
        n_vec++; if (q_count !== 3'd2 || inflight !== 2'd2) begin
            n_err++; $display("FAIL b2b_enq_deq: got q=%0d inf=%0d required 2 2", q_count, inflight); end
        drain();
        n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL sb_empty: got %0d required 0", sb.size()); end
    endtask

    task automatic test_err_clken();
        t_resp_valid = 1'b1; t_resp_status = 3'd2; t_resp_data = 32'h0000_55AA;
        resp_ready = 1'b0;
        #1;
        n_vec++; if (t_resp_ready !== 1'b0) begin n_err++; $display("FAIL resp_ready_pass: got %b required 0", t_resp_ready); end
        resp_ready = 1'b1;
        #1;
        n_vec++; if (resp_valid !== 1'b1 || resp_status !== 3'd2 || resp_data !== 32'h0000_55AA || t_resp_ready !== 1'b1) begin
            n_err++; $display("FAIL stray_forward: got %b %0d %h %b required 1 2 000055aa 1", resp_valid, resp_status, resp_data, t_resp_ready); end
        step();
        t_resp_valid = 1'b0;
        step();
        step();
        n_vec++; if (err !== 1'b1 || inflight !== 2'd0) begin
            n_err++; $display("FAIL stray_err: got err=%b inf=%0d required 1 0", err, inflight); end
        clk_en = 1'b0;
        set_req(32'd77, 32'd78, 10'd79);
        req_valid = 1'b1;
        #1;
        n_vec++; if (t_req_valid !== 1'b0) begin n_err++; $display("FAIL clken_valid: got %b required 0", t_req_valid); end
        step();
        step();
        n_vec++; if (q_count !== 3'd0 || err !== 1'b1) begin
            n_err++; $display("FAIL clken_hold: got q=%0d err=%b required 0 1", q_count, err); end
        req_valid = 1'b0;
        clk_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        t_req_ready = 1'b1;
        t_resp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_req(32'(30 + i), $urandom, 10'($urandom));
            req_valid = 1'b1;
            step();
        end
        req_valid = 1'b0;
        #1;
        n_vec++; if (q_count !== 3'd3 || inflight !== 2'd2) begin
            n_err++; $display("FAIL mid_setup: got q=%0d inf=%0d required 3 2", q_count, inflight); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        #1;
        n_vec++; if (q_count !== 3'd0 || inflight !== 2'd0 || err !== 1'b0) begin
            n_err++; $display("FAIL mid_reset_counts: got q=%0d inf=%0d err=%b required 0 0 0", q_count, inflight, err); end
        n_vec++; if (t_req_valid !== 1'b0 || req_ready !== 1'b0) begin
            n_err++; $display("FAIL mid_reset_hs: got valid=%b ready=%b required 0 0", t_req_valid, req_ready); end
        step();
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready_after: got %b required 1", req_ready); end
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b1;
        req_valid = 1'b0; req_cxu = 1'b0; req_state = 1'b0; req_insn = 1'b0;
        req_func = '0; req_data0 = '0; req_data1 = '0;
        resp_ready = 1'b1; t_req_ready = 1'b1;
        t_resp_valid = 1'b0; t_resp_status = '0; t_resp_data = '0;
        test_reset();
        test_single();
        test_fill();
        test_inflight_cap();
        test_back_to_back();
        test_err_clken();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

endmodule
